// File: rtl/control_unit.sv
// control_unit: multi-cycle control for the 32-bit RISC CPU.
// Decodes the instruction word into register indices, the sign-extended
// immediate and datapath selects. A fixed 4-state cycle (fetch, decode,
// execute, writeback) emits one-cycle enable strobes for each instruction.
module control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  flag,
  input  logic [31:0] Instruction,
  output logic [4:0]  opcode,
  output logic [3:0]  Rd,
  output logic [3:0]  Rs,
  output logic [3:0]  Rt,
  output logic [31:0] imm_ext,
  output logic        in2_muxcontrol,
  output logic        wv_muxcontrol,
  output logic [4:0]  alu_control,
  output logic        regwrite,
  output logic        mem_load,
  output logic        mem_store,
  output logic        jump,
  output logic        en_fetch_pulse,
  output logic        en_exe_pulse,
  output logic        en_pc_pulse
);

  localparam logic [1:0] FETCH     = 2'd0;
  localparam logic [1:0] DECODE    = 2'd1;
  localparam logic [1:0] EXECUTE   = 2'd2;
  localparam logic [1:0] WRITEBACK = 2'd3;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_MOV   = 5'b00001;
  localparam logic [4:0] OP_ADD   = 5'b00010;
  localparam logic [4:0] OP_SUB   = 5'b00011;
  localparam logic [4:0] OP_AND   = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_SUBI  = 5'b00110;
  localparam logic [4:0] OP_ANDI  = 5'b00111;
  localparam logic [4:0] OP_OR    = 5'b01000;
  localparam logic [4:0] OP_XOR   = 5'b01001;
  localparam logic [4:0] OP_SLL   = 5'b01010;
  localparam logic [4:0] OP_SRL   = 5'b01011;
  localparam logic [4:0] OP_ORI   = 5'b01100;
  localparam logic [4:0] OP_XORI  = 5'b01101;
  localparam logic [4:0] OP_CMP   = 5'b01110;
  localparam logic [4:0] OP_LDI   = 5'b01111;
  localparam logic [4:0] OP_LOAD  = 5'b10000;
  localparam logic [4:0] OP_STORE = 5'b10001;
  localparam logic [4:0] OP_JMP   = 5'b11000;
  localparam logic [4:0] OP_JZ    = 5'b11001;
  localparam logic [4:0] OP_JN    = 5'b11010;

  localparam logic [4:0] ALU_PASS_A = 5'b00000;
  localparam logic [4:0] ALU_ADD    = 5'b00001;
  localparam logic [4:0] ALU_SUB    = 5'b00010;
  localparam logic [4:0] ALU_AND    = 5'b00011;
  localparam logic [4:0] ALU_OR     = 5'b00100;
  localparam logic [4:0] ALU_XOR    = 5'b00101;
  localparam logic [4:0] ALU_SLL    = 5'b00110;
  localparam logic [4:0] ALU_SRL    = 5'b00111;
  localparam logic [4:0] ALU_PASS_B = 5'b01000;

  logic [1:0] state;
  logic [1:0] state_next;
  logic       is_write;
  logic       is_load;
  logic       is_store;
  logic       take_jump;
  logic       jump_class;

  // Field extraction, valid at all times including reset
  assign opcode     = Instruction[31:27];
  assign Rd         = Instruction[26:23];
  assign Rs         = Instruction[22:19];
  assign Rt         = Instruction[18:15];
  assign jump_class = (Instruction[31:30] == 2'b11);

  // Jumps carry a 27-bit target offset; everything else a 19-bit immediate
  always_comb begin
    if (jump_class)
      imm_ext = {{5{Instruction[26]}}, Instruction[26:0]};
    else
      imm_ext = {{13{Instruction[18]}}, Instruction[18:0]};
  end

  // Opcode decode: ALU op, operand/write-value selects and instruction class
  always_comb begin
    alu_control    = ALU_PASS_A;
    in2_muxcontrol = 1'b0;
    wv_muxcontrol  = 1'b0;
    is_write       = 1'b0;
    is_load        = 1'b0;
    is_store       = 1'b0;
    take_jump      = 1'b0;
    case (opcode)
      OP_MOV:   begin alu_control = ALU_PASS_A; is_write = 1'b1; end
      OP_ADD:   begin alu_control = ALU_ADD;    is_write = 1'b1; end
      OP_SUB:   begin alu_control = ALU_SUB;    is_write = 1'b1; end
      OP_AND:   begin alu_control = ALU_AND;    is_write = 1'b1; end
      OP_ADDI:  begin alu_control = ALU_ADD; in2_muxcontrol = 1'b1; is_write = 1'b1; end
      OP_SUBI:  begin alu_control = ALU_SUB; in2_muxcontrol = 1'b1; is_write = 1'b1; end
      OP_ANDI:  begin alu_control = ALU_AND; in2_muxcontrol = 1'b1; is_write = 1'b1; end
      OP_OR:    begin alu_control = ALU_OR;     is_write = 1'b1; end
      OP_XOR:   begin alu_control = ALU_XOR;    is_write = 1'b1; end
      OP_SLL:   begin alu_control = ALU_SLL;    is_write = 1'b1; end
      OP_SRL:   begin alu_control = ALU_SRL;    is_write = 1'b1; end
      OP_ORI:   begin alu_control = ALU_OR;  in2_muxcontrol = 1'b1; is_write = 1'b1; end
      OP_XORI:  begin alu_control = ALU_XOR; in2_muxcontrol = 1'b1; is_write = 1'b1; end
      OP_CMP:   begin alu_control = ALU_SUB; end
      OP_LDI:   begin alu_control = ALU_PASS_B; in2_muxcontrol = 1'b1; is_write = 1'b1; end
      OP_LOAD:  begin
        alu_control    = ALU_ADD;
        in2_muxcontrol = 1'b1;
        wv_muxcontrol  = 1'b1;
        is_write       = 1'b1;
        is_load        = 1'b1;
      end
      OP_STORE: begin alu_control = ALU_ADD; in2_muxcontrol = 1'b1; is_store = 1'b1; end
      OP_JMP:   take_jump = 1'b1;
      OP_JZ:    take_jump = flag[0];
      OP_JN:    take_jump = flag[1];
      default:  ;
    endcase
  end

  // Fixed fetch -> decode -> execute -> writeback rotation
  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:     state_next = DECODE;
      DECODE:    state_next = EXECUTE;
      EXECUTE:   state_next = WRITEBACK;
      WRITEBACK: state_next = FETCH;
      default:   state_next = FETCH;
    endcase
  end

  // State register; reset returns to FETCH immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= FETCH;
    else
      state <= state_next;
  end

  // Strobes from state and instruction class; all held low during reset
  always_comb begin
    en_fetch_pulse = 1'b0;
    en_exe_pulse   = 1'b0;
    en_pc_pulse    = 1'b0;
    regwrite       = 1'b0;
    mem_load       = 1'b0;
    mem_store      = 1'b0;
    jump           = 1'b0;
    if (reset) begin
      case (state)
        FETCH:   en_fetch_pulse = 1'b1;
        EXECUTE: begin
          en_exe_pulse = 1'b1;
          mem_load     = is_load;
        end
        WRITEBACK: begin
          en_pc_pulse = 1'b1;
          regwrite    = is_write;
          mem_load    = is_load;
          mem_store   = is_store;
          jump        = take_jump;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-cycle strobe scoreboard plus
// decode checks against hand-derived constants.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  flag;
  logic [31:0] Instruction;
  logic [4:0]  opcode;
  logic [3:0]  Rd, Rs, Rt;
  logic [31:0] imm_ext;
  logic        in2_muxcontrol, wv_muxcontrol;
  logic [4:0]  alu_control;
  logic        regwrite, mem_load, mem_store, jump;
  logic        en_fetch_pulse, en_exe_pulse, en_pc_pulse;

  int checks = 0;
  int errors = 0;

  // {fetch, exe, pc, regwrite, mem_load, mem_store, jump}
  logic [6:0] strobes;
  logic [6:0] exp_q [$];
  logic [6:0] exp_v;

  assign strobes = {en_fetch_pulse, en_exe_pulse, en_pc_pulse,
                    regwrite, mem_load, mem_store, jump};

  control_unit dut (
    .clk(clk), .reset(reset), .flag(flag), .Instruction(Instruction),
    .opcode(opcode), .Rd(Rd), .Rs(Rs), .Rt(Rt), .imm_ext(imm_ext),
    .in2_muxcontrol(in2_muxcontrol), .wv_muxcontrol(wv_muxcontrol),
    .alu_control(alu_control), .regwrite(regwrite), .mem_load(mem_load),
    .mem_store(mem_store), .jump(jump), .en_fetch_pulse(en_fetch_pulse),
    .en_exe_pulse(en_exe_pulse), .en_pc_pulse(en_pc_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit expired, got running want finished");
    $fatal(1, "watchdog");
  end

  // Expected strobes for one full instruction, one entry per cycle
  task automatic push_instr(input logic wr, input logic ld, input logic st, input logic jp);
    exp_q.push_back(7'b1000000);
    exp_q.push_back(7'b0000000);
    exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, ld, 1'b0, 1'b0});
    exp_q.push_back({1'b0, 1'b0, 1'b1, wr, ld, st, jp});
  endtask

  task automatic test_reset();
    reset = 1'b0; flag = 2'b00; Instruction = 32'h7880_0003;
    @(negedge clk);
    checks++;
    if (strobes !== 7'b0) begin
      errors++; $display("FAIL reset_strobes got %b want %b", strobes, 7'b0);
    end
    checks++;
    if (opcode !== 5'd15 || imm_ext !== 32'd3) begin
      errors++; $display("FAIL reset_decode got op=%0d imm=%h want op=15 imm=00000003", opcode, imm_ext);
    end
    Instruction = 32'h0000_0000;
    @(posedge clk); #1 reset = 1'b1;
    push_instr(1'b0, 1'b0, 1'b0, 1'b0);
    push_instr(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (8) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (strobes !== exp_v) begin
        errors++; $display("FAIL reset_period got %b want %b", strobes, exp_v);
      end
    end
  endtask

  task automatic test_ldi();
    Instruction = 32'h7880_0003; flag = 2'b00;
    push_instr(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (opcode !== 5'd15 || Rd !== 4'd1 || imm_ext !== 32'd3 ||
        in2_muxcontrol !== 1'b1 || alu_control !== 5'b01000 || wv_muxcontrol !== 1'b0) begin
      errors++;
      $display("FAIL ldi_decode got op=%0d rd=%0d imm=%h in2=%b alu=%b wv=%b want 15 1 00000003 1 01000 0",
               opcode, Rd, imm_ext, in2_muxcontrol, alu_control, wv_muxcontrol);
    end
    repeat (4) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (strobes !== exp_v) begin
        errors++; $display("FAIL ldi_strobes got %b want %b", strobes, exp_v);
      end
    end
  endtask

  task automatic test_add();
    Instruction = 32'h1189_0000;
    push_instr(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (opcode !== 5'd2 || Rd !== 4'd3 || Rs !== 4'd1 || Rt !== 4'd2 ||
        in2_muxcontrol !== 1'b0 || alu_control !== 5'b00001) begin
      errors++;
      $display("FAIL add_decode got op=%0d rd=%0d rs=%0d rt=%0d in2=%b alu=%b want 2 3 1 2 0 00001",
               opcode, Rd, Rs, Rt, in2_muxcontrol, alu_control);
    end
    repeat (4) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (strobes !== exp_v) begin
        errors++; $display("FAIL add_strobes got %b want %b", strobes, exp_v);
      end
    end
  endtask

  task automatic test_addi();
    Instruction = 32'h2A10_0001;
    push_instr(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (opcode !== 5'd5 || Rd !== 4'd4 || Rs !== 4'd2 || imm_ext !== 32'd1 ||
        in2_muxcontrol !== 1'b1 || alu_control !== 5'b00001) begin
      errors++;
      $display("FAIL addi_decode got op=%0d rd=%0d rs=%0d imm=%h in2=%b alu=%b want 5 4 2 00000001 1 00001",
               opcode, Rd, Rs, imm_ext, in2_muxcontrol, alu_control);
    end
    repeat (4) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (strobes !== exp_v) begin
        errors++; $display("FAIL addi_strobes got %b want %b", strobes, exp_v);
      end
    end
    // All-ones 19-bit field must sign-extend to -1; bit 18 alone to 0xFFFC0000
    Instruction = 32'h2A17_FFFF;
    push_instr(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (imm_ext !== 32'hFFFF_FFFF || Rs !== 4'd2) begin
      errors++; $display("FAIL addi_imm_neg got imm=%h rs=%0d want FFFFFFFF 2", imm_ext, Rs);
    end
    repeat (4) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (strobes !== exp_v) begin
        errors++; $display("FAIL addi_neg_strobes got %b want %b", strobes, exp_v);
      end
    end
    Instruction = 32'h2A14_0000;
    #1;
    checks++;
    if (imm_ext !== 32'hFFFC_0000) begin
      errors++; $display("FAIL addi_imm_bit18 got %h want FFFC0000", imm_ext);
    end
  endtask

  task automatic test_jump();
    logic [31:0] j_ins [6] = '{32'hC000_0002, 32'hC800_0002, 32'hC800_0002,
                               32'hD000_0002, 32'hD000_0002, 32'hF800_0002};
    logic [1:0]  j_flg [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b11};
    logic        j_tkn [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      Instruction = j_ins[i]; flag = j_flg[i];
      push_instr(1'b0, 1'b0, 1'b0, j_tkn[i]);
      #1;
      checks++;
      if (imm_ext !== 32'd2) begin
        errors++; $display("FAIL jump_imm[%0d] got %h want 00000002", i, imm_ext);
      end
      repeat (4) begin
        @(negedge clk);
        exp_v = exp_q.pop_front();
        checks++;
        if (strobes !== exp_v) begin
          errors++; $display("FAIL jump_strobes[%0d] got %b want %b", i, strobes, exp_v);
        end
      end
    end
    flag = 2'b00;
    // 27-bit jump offsets sign-extend from bit 26
    Instruction = 32'hC7FF_FFFF;
    #1;
    checks++;
    if (imm_ext !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL jump_imm_ones got %h want FFFFFFFF", imm_ext);
    end
    Instruction = 32'hC400_0000;
    #1;
    checks++;
    if (imm_ext !== 32'hFC00_0000) begin
      errors++; $display("FAIL jump_imm_bit26 got %h want FC000000", imm_ext);
    end
  endtask

  task automatic test_alu_ops();
    logic [31:0] a_ins [14] = '{32'h0800_0000, 32'h1800_0000, 32'h2000_0000, 32'h3000_0000,
                                32'h3800_0000, 32'h4000_0000, 32'h4800_0000, 32'h5000_0000,
                                32'h5800_0000, 32'h6000_0000, 32'h6800_0000, 32'h7000_0000,
                                32'h0000_0000, 32'h9000_0000};
    logic [4:0]  a_alu [14] = '{5'b00000, 5'b00010, 5'b00011, 5'b00010, 5'b00011, 5'b00100,
                                5'b00101, 5'b00110, 5'b00111, 5'b00100, 5'b00101, 5'b00010,
                                5'b00000, 5'b00000};
    logic        a_in2 [14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        a_wr  [14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 14; i++) begin
      Instruction = a_ins[i];
      push_instr(a_wr[i], 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (alu_control !== a_alu[i] || in2_muxcontrol !== a_in2[i] || wv_muxcontrol !== 1'b0) begin
        errors++;
        $display("FAIL alu_decode[%0d] got alu=%b in2=%b wv=%b want %b %b 0",
                 i, alu_control, in2_muxcontrol, wv_muxcontrol, a_alu[i], a_in2[i]);
      end
      repeat (4) begin
        @(negedge clk);
        exp_v = exp_q.pop_front();
        checks++;
        if (strobes !== exp_v) begin
          errors++; $display("FAIL alu_strobes[%0d] got %b want %b", i, strobes, exp_v);
        end
      end
    end
  endtask

  task automatic test_load_store();
    Instruction = 32'h8090_0010;
    push_instr(1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (wv_muxcontrol !== 1'b1 || in2_muxcontrol !== 1'b1 || alu_control !== 5'b00001 ||
        Rd !== 4'd1 || Rs !== 4'd2 || imm_ext !== 32'h10) begin
      errors++;
      $display("FAIL load_decode got wv=%b in2=%b alu=%b rd=%0d rs=%0d imm=%h want 1 1 00001 1 2 00000010",
               wv_muxcontrol, in2_muxcontrol, alu_control, Rd, Rs, imm_ext);
    end
    repeat (4) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (strobes !== exp_v) begin
        errors++; $display("FAIL load_strobes got %b want %b", strobes, exp_v);
      end
    end
    Instruction = 32'h8890_0010;
    push_instr(1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    checks++;
    if (wv_muxcontrol !== 1'b0 || in2_muxcontrol !== 1'b1 || alu_control !== 5'b00001) begin
      errors++;
      $display("FAIL store_decode got wv=%b in2=%b alu=%b want 0 1 00001",
               wv_muxcontrol, in2_muxcontrol, alu_control);
    end
    repeat (4) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (strobes !== exp_v) begin
        errors++; $display("FAIL store_strobes got %b want %b", strobes, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    Instruction = 32'h8890_0010;
    exp_q.push_back(7'b1000000);
    exp_q.push_back(7'b0000000);
    repeat (2) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (strobes !== exp_v) begin
        errors++; $display("FAIL abort_pre got %b want %b", strobes, exp_v);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (strobes !== 7'b0100000) begin
      errors++; $display("FAIL abort_exec got %b want %b", strobes, 7'b0100000);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (strobes !== 7'b0) begin
      errors++; $display("FAIL abort_async got %b want %b", strobes, 7'b0);
    end
    @(negedge clk);
    checks++;
    if (strobes !== 7'b0) begin
      errors++; $display("FAIL abort_held got %b want %b", strobes, 7'b0);
    end
    @(posedge clk); #1 reset = 1'b1;
    // Restart must be a fresh FETCH, not the aborted instruction's writeback
    push_instr(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (strobes !== exp_v) begin
        errors++; $display("FAIL abort_restart got %b want %b", strobes, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_add();
    test_addi();
    test_jump();
    test_alu_ops();
    test_load_store();
    test_reset_mid();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
